// File: rtl/alarm_controller.sv
// Alarm system sequencer: arm/disarm FSM, exit/entry delays, siren and
// wrong-code lockout. Gates the code detector and consumes its results.
module alarm_controller #(
    parameter int unsigned N_SENSORS      = 4,
    parameter int unsigned EXIT_CYCLES    = 1000,
    parameter int unsigned ENTRY_CYCLES   = 2000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 4000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm_req,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic                 seq_ok,
    input  logic                 seq_fail,
    output logic                 det_enable,
    output logic                 det_clear,
    output logic                 armed,
    output logic                 siren,
    output logic [2:0]           state,
    output logic [1:0]           fail_cnt
);

    localparam int unsigned MAX_DELAY_A = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int unsigned MAX_DELAY   = (MAX_DELAY_A > LOCKOUT_CYCLES) ? MAX_DELAY_A : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W     = ($clog2(MAX_DELAY) < 1) ? 1 : $clog2(MAX_DELAY);

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4,
        LOCKOUT     = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           fail_q, fail_d;
    logic                 clear_q, clear_d;
    logic                 den_q, den_d;
    logic                 armed_q, armed_d;
    logic                 siren_q, siren_d;
    logic [2:0]           fail_inc;

    // State, timer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISARMED;
            timer_q <= '0;
            fail_q  <= '0;
            clear_q <= 1'b0;
            den_q   <= 1'b0;
            armed_q <= 1'b0;
            siren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            clear_q <= clear_d;
            den_q   <= den_d;
            armed_q <= armed_d;
            siren_q <= siren_d;
        end
    end

    // Next state: per-state sequencing first, then code results override it
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        clear_d  = 1'b0;
        fail_inc = {1'b0, fail_q} + 3'd1;

        case (state_q)
            DISARMED: begin
                timer_d = '0;
                if (arm_req) begin
                    state_d = EXIT_DELAY;
                    timer_d = TIMER_W'(EXIT_CYCLES - 1);
                    clear_d = 1'b1;
                end
            end
            EXIT_DELAY: begin
                if (timer_q == '0) state_d = ARMED;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            ARMED: begin
                timer_d = '0;
                if (|sensor) begin
                    state_d = ENTRY_DELAY;
                    timer_d = TIMER_W'(ENTRY_CYCLES - 1);
                end
            end
            ENTRY_DELAY: begin
                if (timer_q == '0) state_d = ALARM;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            ALARM: begin
                timer_d = '0;
            end
            LOCKOUT: begin
                if (timer_q == '0) state_d = ALARM;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            default: begin
                state_d = DISARMED;
                timer_d = '0;
                fail_d  = '0;
            end
        endcase

        // Detector results only count while code entry is enabled
        if (den_q) begin
            if (seq_ok) begin
                state_d = DISARMED;
                timer_d = '0;
                fail_d  = '0;
                clear_d = 1'b1;
            end else if (seq_fail) begin
                clear_d = 1'b1;
                if (fail_inc >= 3'(MAX_FAILS)) begin
                    state_d = LOCKOUT;
                    timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
                    fail_d  = '0;
                end else begin
                    fail_d  = fail_inc[1:0];
                end
            end
        end
    end

    // Output flags registered alongside the state they describe
    always_comb begin
        den_d   = (state_d == EXIT_DELAY) || (state_d == ARMED) ||
                  (state_d == ENTRY_DELAY) || (state_d == ALARM);
        armed_d = (state_d == EXIT_DELAY) || (state_d == ARMED) ||
                  (state_d == ENTRY_DELAY);
        siren_d = (state_d == ALARM) || (state_d == LOCKOUT);
    end

    assign det_enable = den_q;
    assign det_clear  = clear_q;
    assign armed      = armed_q;
    assign siren      = siren_q;
    assign state      = state_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: driver queues the expected
// post-edge outputs per cycle, monitor pops and compares after each edge.
module tb_alarm_controller;

    logic       clk;
    logic       rst;
    logic       arm_req;
    logic [3:0] sensor;
    logic       seq_ok;
    logic       seq_fail;
    logic       det_enable;
    logic       det_clear;
    logic       armed;
    logic       siren;
    logic [2:0] state;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    // expected {state[2:0], fail_cnt[1:0], det_clear}
    logic [5:0] exp_q[$];

    alarm_controller #(
        .N_SENSORS(4), .EXIT_CYCLES(4), .ENTRY_CYCLES(8),
        .MAX_FAILS(3), .LOCKOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .arm_req(arm_req), .sensor(sensor),
        .seq_ok(seq_ok), .seq_fail(seq_fail), .det_enable(det_enable),
        .det_clear(det_clear), .armed(armed), .siren(siren),
        .state(state), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Monitor: compare each queued expectation just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [5:0] e;
                logic [2:0] es;
                e  = exp_q.pop_front();
                es = e[5:3];
                cmp("state",      int'(state),      int'(es));
                cmp("fail_cnt",   int'(fail_cnt),   int'(e[2:1]));
                cmp("det_clear",  int'(det_clear),  int'(e[0]));
                cmp("armed",      int'(armed),      int'(es >= 3'd1 && es <= 3'd3));
                cmp("siren",      int'(siren),      int'(es == 3'd4 || es == 3'd5));
                cmp("det_enable", int'(det_enable), int'(es >= 3'd1 && es <= 3'd4));
            end
        end
    end

    // One cycle of stimulus plus the outputs expected after the next edge
    task automatic st(input logic a, input logic [3:0] s, input logic ok, input logic f,
                      input logic [2:0] es, input logic [1:0] ef, input logic ec);
        @(negedge clk);
        arm_req  = a;
        sensor   = s;
        seq_ok   = ok;
        seq_fail = f;
        exp_q.push_back({es, ef, ec});
    endtask

    task automatic idle(input int n, input logic [2:0] es, input logic [1:0] ef);
        for (int i = 0; i < n; i++) st(1'b0, 4'd0, 1'b0, 1'b0, es, ef, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_state"},  int'(state),      0);
        cmp({tag, "_fail"},   int'(fail_cnt),   0);
        cmp({tag, "_clear"},  int'(det_clear),  0);
        cmp({tag, "_armed"},  int'(armed),      0);
        cmp({tag, "_siren"},  int'(siren),      0);
        cmp({tag, "_den"},    int'(det_enable), 0);
    endtask

    // Asynchronous reset asserted between edges, checked before any edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        arm_req = 1'b0; sensor = 4'd0; seq_ok = 1'b0; seq_fail = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic arm_to_armed(input logic [1:0] ef);
        st(1'b1, 4'd0, 1'b0, 1'b0, 3'd1, ef, 1'b1);
        idle(3, 3'd1, ef);
        idle(1, 3'd2, ef);
    endtask

    initial begin
        rst = 1'b1; arm_req = 1'b0; sensor = 4'd0; seq_ok = 1'b0; seq_fail = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 1: arm, exit delay of 4 cycles
        arm_to_armed(2'd0);

        // 2: sensor trip, entry delay, alarm, disarm
        st(1'b0, 4'b0010, 1'b0, 1'b0, 3'd3, 2'd0, 1'b0);
        idle(7, 3'd3, 2'd0);
        idle(1, 3'd4, 2'd0);
        idle(2, 3'd4, 2'd0);
        st(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        st(1'b0, 4'b1111, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0);

        // 3: disarm during entry delay, then seq_ok ignored when disarmed
        arm_to_armed(2'd0);
        st(1'b0, 4'b0001, 1'b0, 1'b0, 3'd3, 2'd0, 1'b0);
        idle(4, 3'd3, 2'd0);
        st(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        st(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0);

        // 4: three wrong codes in ARMED -> lockout -> alarm
        arm_to_armed(2'd0);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd2, 2'd1, 1'b1);
        idle(1, 3'd2, 2'd1);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd2, 2'd2, 1'b1);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd5, 2'd0, 1'b1);
        st(1'b0, 4'd0, 1'b1, 1'b0, 3'd5, 2'd0, 1'b0);
        idle(14, 3'd5, 2'd0);
        idle(1, 3'd4, 2'd0);

        // 5: ok+fail together in ALARM; fail on the expiry cycle of entry delay
        st(1'b0, 4'd0, 1'b1, 1'b1, 3'd0, 2'd0, 1'b1);
        arm_to_armed(2'd0);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd2, 2'd1, 1'b1);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd2, 2'd2, 1'b1);
        st(1'b0, 4'b1000, 1'b0, 1'b0, 3'd3, 2'd2, 1'b0);
        idle(7, 3'd3, 2'd2);
        st(1'b0, 4'd0, 1'b0, 1'b1, 3'd5, 2'd0, 1'b1);
        idle(15, 3'd5, 2'd0);
        idle(1, 3'd4, 2'd0);

        // 6: async reset mid-ALARM and mid-EXIT_DELAY; arm_req ignored in ARMED
        async_reset("rst_alarm");
        st(1'b1, 4'd0, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1);
        idle(1, 3'd1, 2'd0);
        async_reset("rst_exit");
        arm_to_armed(2'd0);
        st(1'b1, 4'd0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0);
        idle(1, 3'd2, 2'd0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
